// File: rtl/pipe_stage_reg_pkg.sv
// rtl/pipe_stage_reg_pkg.sv - shared constants and mode decode for the inter-stage pipeline register
package pipe_stage_reg_pkg;

    localparam logic        STOP           = 1'b1;
    localparam logic        NOSTOP         = 1'b0;
    localparam logic [31:0] ZeroWord       = 32'h0000_0000;
    localparam logic        NotInDelaySlot = 1'b0;
    localparam logic [7:0]  EXE_NOP_OP     = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP    = 3'b000;

    typedef enum logic [1:0] {
        PS_LOAD   = 2'd0,
        PS_HOLD   = 2'd1,
        PS_BUBBLE = 2'd2,
        PS_FLUSH  = 2'd3
    } ps_mode_e;

    // Flush outranks any stall; the illegal up=0/dn=1 pattern falls through to LOAD.
    function automatic ps_mode_e ps_decode(input logic flush, input logic up, input logic dn);
        if (flush) return PS_FLUSH;
        if (up == STOP && dn == NOSTOP) return PS_BUBBLE;
        if (up == STOP) return PS_HOLD;
        return PS_LOAD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - parametrised pipeline register with stall/flush decode and perf counters
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned       DATA_W    = 128,
    parameter int unsigned       STALL_W   = 6,
    parameter int unsigned       STAGE_IDX = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W     = 16
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_next_ds,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_ds_flag,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   bubble_cnt
);

    if (STAGE_IDX > STALL_W - 2) begin : g_bad_stage_idx
        $error("pipe_stage_reg: STAGE_IDX must be in 0..STALL_W-2");
    end

    logic              up;
    logic              dn;
    ps_mode_e          mode;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              ds_q,    ds_d;

    assign up   = stall[STAGE_IDX];
    assign dn   = stall[STAGE_IDX+1];
    assign mode = ps_decode(flush, up, dn);

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ds_d    = ds_q;
        unique case (mode)
            PS_FLUSH: begin
                valid_d = 1'b0;
                data_d  = NOP_VALUE;
                ds_d    = NotInDelaySlot;
            end
            // ds flag deliberately held so the delay-slot marking survives the bubble
            PS_BUBBLE: begin
                valid_d = 1'b0;
                data_d  = NOP_VALUE;
            end
            PS_HOLD: ;
            PS_LOAD: begin
                valid_d = in_valid;
                data_d  = in_valid ? in_data : NOP_VALUE;
                ds_d    = in_next_ds;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            valid_q <= 1'b0;
            data_q  <= NOP_VALUE;
            ds_q    <= NotInDelaySlot;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ds_q    <= ds_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_data    = data_q;
    assign out_ds_flag = ds_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (cnt_clr),
        .inc ((up == STOP) && !flush),
        .cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .Clk (Clk),
        .Rst (Rst),
        .clr (cnt_clr),
        .inc (mode == PS_BUBBLE),
        .cnt (bubble_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed and randomized checks of pipe_stage_reg against a reference model
module tb_pipe_stage_reg;
    import pipe_stage_reg_pkg::*;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STALL_W = 6;
    localparam int unsigned SIDX    = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int          CNT_MAX = 15;
    localparam logic [DATA_W-1:0] NOP = 32'hA5A5_0000;

    logic               Clk;
    logic               Rst;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic               in_valid;
    logic [DATA_W-1:0]  in_data;
    logic               in_next_ds;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic               out_ds_flag;
    logic               cnt_clr;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   bubble_cnt;

    int n_checks;
    int n_errors;

    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_ds;
    int                m_stall;
    int                m_bub;

    pipe_stage_reg #(
        .DATA_W   (DATA_W),
        .STALL_W  (STALL_W),
        .STAGE_IDX(SIDX),
        .NOP_VALUE(NOP),
        .CNT_W    (CNT_W)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .stall      (stall),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_next_ds (in_next_ds),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ds_flag(out_ds_flag),
        .cnt_clr    (cnt_clr),
        .stall_cnt  (stall_cnt),
        .bubble_cnt (bubble_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (!Rst) assert (!(stall[SIDX] == 1'b0 && stall[SIDX+1] == 1'b1));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = NOP;
        m_ds    = 1'b0;
        m_stall = 0;
        m_bub   = 0;
    endtask

    task automatic model_step();
        logic     up, dn;
        ps_mode_e md;
        up = stall[SIDX];
        dn = stall[SIDX+1];
        if (flush)         md = PS_FLUSH;
        else if (up && !dn) md = PS_BUBBLE;
        else if (up)        md = PS_HOLD;
        else                md = PS_LOAD;
        if (cnt_clr) begin
            m_stall = 0;
            m_bub   = 0;
        end else begin
            if (up && !flush)    m_stall = (m_stall + 1 > CNT_MAX) ? CNT_MAX : m_stall + 1;
            if (md == PS_BUBBLE) m_bub   = (m_bub + 1 > CNT_MAX) ? CNT_MAX : m_bub + 1;
        end
        case (md)
            PS_FLUSH:  begin m_valid = 1'b0; m_data = NOP; m_ds = 1'b0; end
            PS_BUBBLE: begin m_valid = 1'b0; m_data = NOP; end
            PS_HOLD:   ;
            default:   begin m_valid = in_valid; m_data = in_valid ? in_data : NOP; m_ds = in_next_ds; end
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},  64'(out_valid),   64'(m_valid));
        chk({tag, ".data"},   64'(out_data),    64'(m_data));
        chk({tag, ".ds"},     64'(out_ds_flag), 64'(m_ds));
        chk({tag, ".stcnt"},  64'(stall_cnt),   64'(m_stall));
        chk({tag, ".bubcnt"}, 64'(bubble_cnt),  64'(m_bub));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [5:0] st, input logic fl, input logic v,
                         input logic [31:0] d, input logic ds, input logic clr);
        stall      = st;
        flush      = fl;
        in_valid   = v;
        in_data    = d;
        in_next_ds = ds;
        cnt_clr    = clr;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        Rst = 1'b1;
        drive(6'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check_all("reset");
        Rst = 1'b0;

        drive(6'b000000, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0); tick("load11");
        chk("load11_lit", 64'(out_data), 64'h11);
        drive(6'b000000, 1'b0, 1'b1, 32'h22, 1'b0, 1'b0); tick("load22");
        drive(6'b000000, 1'b0, 1'b1, 32'h33, 1'b1, 1'b0); tick("load33");
        chk("load33_lit", 64'(out_data), 64'h33);

        drive(6'b000100, 1'b0, 1'b1, 32'h44, 1'b0, 1'b0);
        tick("bub1");
        tick("bub2");
        chk("bub_ds_held", 64'(out_ds_flag), 64'h1);
        chk("bub_data_nop", 64'(out_data), 64'(NOP));
        chk("bub_cnt2", 64'(bubble_cnt), 64'd2);
        chk("stall_cnt2", 64'(stall_cnt), 64'd2);

        drive(6'b000000, 1'b0, 1'b1, 32'hAB, 1'b0, 1'b1); tick("loadAB");
        drive(6'b001100, 1'b0, 1'b0, 32'h55, 1'b1, 1'b0);
        repeat (3) tick("hold");
        chk("hold_data", 64'(out_data), 64'hAB);
        chk("hold_valid", 64'(out_valid), 64'h1);
        chk("hold_stcnt", 64'(stall_cnt), 64'd3);
        chk("hold_bubcnt", 64'(bubble_cnt), 64'd0);

        drive(6'b000000, 1'b0, 1'b1, 32'h66, 1'b1, 1'b0); tick("load_ds");
        drive(6'b000100, 1'b1, 1'b1, 32'h77, 1'b1, 1'b0); tick("flush");
        chk("flush_ds", 64'(out_ds_flag), 64'h0);
        chk("flush_stcnt", 64'(stall_cnt), 64'd3);

        drive(6'b000000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1); tick("clr");
        drive(6'b000100, 1'b0, 1'b1, 32'h88, 1'b0, 1'b0);
        repeat (20) tick("sat");
        chk("bub_sat", 64'(bubble_cnt), 64'd15);
        chk("stall_sat", 64'(stall_cnt), 64'd15);
        drive(6'b000100, 1'b0, 1'b1, 32'h88, 1'b0, 1'b1); tick("clr_vs_inc");
        chk("clr_bub", 64'(bubble_cnt), 64'd0);
        chk("clr_stall", 64'(stall_cnt), 64'd0);

        for (int i = 0; i < 400; i++) begin
            logic [5:0] st;
            logic       up;
            st       = 6'($urandom);
            up       = 1'($urandom_range(0, 1));
            st[SIDX] = up;
            st[SIDX+1] = up ? 1'($urandom_range(0, 1)) : 1'b0;
            drive(st, ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                  $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
            tick("rand");
        end

        drive(6'b000000, 1'b0, 1'b1, 32'hAB, 1'b1, 1'b0); tick("pre_rst_load");
        drive(6'b001100, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0); tick("pre_rst_hold");
        #3;
        Rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        #1;
        Rst = 1'b0;
        drive(6'b000000, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0); tick("post_rst");
        chk("post_rst_lit", 64'(out_data), 64'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised inter-stage pipeline register, the successor to the fixed ID/EX latch. Instantiated at IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries an opaque DATA_W payload plus a valid bit and a delay-slot feedback flag.
- Adds four features:
  - per-stage stall decode from the global stall vector
  - synchronous flush with priority over stall
  - a delay-slot flag that is preserved across bubbles
  - saturating stall/bubble performance counters

Parameters:
- DATA_W, 128, payload width in bits.
- STALL_W, 6, width of the global stall vector.
- STAGE_IDX, 2, index of the upstream stage. Bit STAGE_IDX is the upstream stall; bit STAGE_IDX+1 is the downstream stall. Legal range is 0..STALL_W-2.
- NOP_VALUE, {DATA_W{1'b0}}, payload driven on reset, bubble and flush.
- CNT_W, 16, width of the performance counters.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- stall  in  STALL_W  global stall vector; 1 = STOP.
- flush  in  1  synchronous flush from the exception/control unit.
- in_valid  in  1  upstream payload valid.
- in_data  in  DATA_W  upstream payload.
- in_next_ds  in  1  next upstream instruction is in a delay slot.
- out_valid  out  1  registered valid.
- out_data  out  DATA_W  registered payload.
- out_ds_flag  out  1  registered delay-slot flag, fed back to the upstream stage.
- cnt_clr  in  1  synchronous clear of both counters.
- stall_cnt  out  CNT_W  cycles with the upstream stage stalled.
- bubble_cnt  out  CNT_W  bubbles inserted.

Behaviour:
- Reset: Rst asserted asynchronously forces all outputs immediately: out_valid=0, out_data=NOP_VALUE, out_ds_flag=0, stall_cnt=0, bubble_cnt=0. Reset mid-stall or mid-flush discards all state.
- Decode: up = stall[STAGE_IDX], dn = stall[STAGE_IDX+1]. All updates happen on posedge Clk. Priority, highest first:
  1. FLUSH (flush=1): out_valid=0, out_data=NOP_VALUE, out_ds_flag=0. Flush wins regardless of the stall bits.
  2. BUBBLE (up=1, dn=0): out_valid=0, out_data=NOP_VALUE. out_ds_flag is HELD, so the delay-slot marking survives the stall.
  3. HOLD (up=1, dn=1): all three outputs keep their values.
  4. LOAD (up=0): out_valid=in_valid; out_data=in_valid ? in_data : NOP_VALUE; out_ds_flag=in_next_ds.
- Illegal stall pattern (up=0, dn=1): treated as LOAD, per rule 4. The stall controller never generates this pattern; it is an assertion target in the bench.
- Latency: exactly 1 cycle from in_* to out_* on LOAD. There is no combinational path from any input to any output.
- stall_cnt:
  - Increments by 1 in every cycle with up=1 and flush=0.
  - Saturates at all-ones and never wraps.
- bubble_cnt:
  - Increments by 1 in every BUBBLE cycle.
  - Saturates at all-ones.
- cnt_clr: on the next edge, sets both counters to 0. Clear beats increment in the same cycle. cnt_clr does not affect the pipeline outputs.
- Elaboration check: STAGE_IDX > STALL_W-2 is an elaboration error (generate-time $error).
- No internal FSM beyond the 4-way mode decode. All state lives in the output registers and the two counters.

Decomposition:
- Shared package/define file holds:
  - STOP=1'b1, NOSTOP=1'b0
  - ZeroWord, NotInDelaySlot, the NOP aluop/alusel encodings
  - mode encoding PS_LOAD/PS_HOLD/PS_BUBBLE/PS_FLUSH, used by the bench for coverage
- Sub-module: sat_counter with parameter W and ports Clk, Rst, clr, inc, cnt. It is instantiated twice.

Test Plan:
- Reset, then 3 cycles with stall=0, in_valid=1, in_data=0x11,0x22,0x33 -> out_data=0x11,0x22,0x33 one cycle later; out_valid=1; counters stay 0.
- stall=6'b000100 (STAGE_IDX=2) for 2 cycles, in_next_ds=1 loaded beforehand -> out_valid=0, out_data=NOP_VALUE, out_ds_flag stays 1, bubble_cnt=2, stall_cnt=2.
- stall=6'b001100 for 3 cycles after loading 0xAB -> out_data holds 0xAB, out_valid holds 1, bubble_cnt unchanged, stall_cnt=3.
- flush=1 together with stall=6'b000100 while out_ds_flag=1 -> out_valid=0, out_data=NOP_VALUE, out_ds_flag=0, stall_cnt and bubble_cnt unchanged.
- CNT_W=4: bubble for 20 cycles -> bubble_cnt saturates at 15. Then cnt_clr=1 with a bubble in the same cycle -> both counters 0.
- Assert Rst asynchronously between edges during a HOLD holding 0xAB -> outputs go to reset values before the next edge; the first LOAD after release passes in_data unchanged.
